// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the core always has priority; a single host request is
// latched, issued on the first core-idle cycle, and read data returned one cycle later.
module dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_core_req,
  output logic            o_core_gnt,
  input  logic [XLEN-1:0] i_core_addr,
  input  logic [XLEN-1:0] i_core_wr_data,
  input  logic [3:0]      i_core_size,
  input  logic            i_core_read,
  input  logic            i_core_write,
  output logic [XLEN-1:0] o_core_rd_data,
  input  logic            i_host_valid,
  output logic            o_host_ready,
  input  logic [XLEN-1:0] i_host_addr,
  input  logic [XLEN-1:0] i_host_wr_data,
  input  logic [3:0]      i_host_size,
  input  logic            i_host_write,
  output logic            o_host_rd_valid,
  output logic [XLEN-1:0] o_host_rd_data,
  output logic            o_host_starved,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wr_data,
  output logic [3:0]      o_mem_size,
  output logic            o_mem_read,
  output logic            o_mem_write,
  input  logic [XLEN-1:0] i_mem_rd_data
);

  // state | meaning
  // IDLE  | ready to accept a host request
  // PEND  | host request latched, waiting for a core-idle cycle
  // RESP  | host read data on i_mem_rd_data this cycle
  typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] req_addr, req_wr_data;
  logic [3:0]      req_size;
  logic            req_write;
  logic [7:0]      wait_cnt;
  logic            host_issue;

  assign host_issue = (state == PEND) && !i_core_req;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_host_valid) state_nxt = PEND;
      PEND:    if (!i_core_req)  state_nxt = req_write ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_addr    <= '0;
      req_wr_data <= '0;
      req_size    <= '0;
      req_write   <= 1'b0;
    end else if (state == IDLE && i_host_valid) begin
      req_addr    <= i_host_addr;
      req_wr_data <= i_host_wr_data;
      req_size    <= i_host_size;
      req_write   <= i_host_write;
    end
  end

  // Counts core-blocked PEND cycles; saturates so the starved flag never drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                         wait_cnt <= '0;
    else if (state != PEND || host_issue) wait_cnt <= '0;
    else if (wait_cnt != 8'hFF)        wait_cnt <= wait_cnt + 8'd1;
  end

  always_comb begin
    o_mem_addr    = '0;
    o_mem_wr_data = '0;
    o_mem_size    = '0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    if (i_core_req) begin
      o_mem_addr    = i_core_addr;
      o_mem_wr_data = i_core_wr_data;
      o_mem_size    = i_core_size;
      o_mem_read    = i_core_read;
      o_mem_write   = i_core_write;
    end else if (host_issue) begin
      o_mem_addr    = req_addr;
      o_mem_wr_data = req_wr_data;
      o_mem_size    = req_size;
      o_mem_read    = !req_write;
      o_mem_write   = req_write;
    end
  end

  assign o_core_gnt      = i_core_req;
  assign o_core_rd_data  = i_mem_rd_data;
  assign o_host_ready    = (state == IDLE);
  assign o_host_rd_valid = (state == RESP);
  assign o_host_rd_data  = (state == RESP) ? i_mem_rd_data : '0;
  assign o_host_starved  = (state == PEND) && (wait_cnt >= 8'(STARVE_LIMIT));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-enabled SRAM model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_gnt, core_read, core_write;
  logic [31:0] core_addr, core_wr_data, core_rd_data;
  logic [3:0]  core_size;
  logic        host_valid, host_ready, host_write, host_rd_valid, host_starved;
  logic [31:0] host_addr, host_wr_data, host_rd_data;
  logic [3:0]  host_size;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [3:0]  mem_size;
  logic        mem_read, mem_write;

  logic [31:0] sram [0:63];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(32), .STARVE_LIMIT(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_req(core_req), .o_core_gnt(core_gnt),
    .i_core_addr(core_addr), .i_core_wr_data(core_wr_data),
    .i_core_size(core_size), .i_core_read(core_read), .i_core_write(core_write),
    .o_core_rd_data(core_rd_data),
    .i_host_valid(host_valid), .o_host_ready(host_ready),
    .i_host_addr(host_addr), .i_host_wr_data(host_wr_data),
    .i_host_size(host_size), .i_host_write(host_write),
    .o_host_rd_valid(host_rd_valid), .o_host_rd_data(host_rd_data),
    .o_host_starved(host_starved),
    .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wr_data), .o_mem_size(mem_size),
    .o_mem_read(mem_read), .o_mem_write(mem_write),
    .i_mem_rd_data(mem_rd_data)
  );

  initial begin
    for (int i = 0; i < 64; i++) sram[i] = 32'hA000_0000 + 32'(i);
    mem_rd_data = '0;
  end

  always @(posedge clk) begin
    if (mem_read) mem_rd_data <= sram[mem_addr[7:2]];
    if (mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_size[b]) sram[mem_addr[7:2]][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #3;
  endtask

  task automatic core_idle;
    core_req = 0; core_read = 0; core_write = 0;
    core_addr = '0; core_wr_data = '0; core_size = '0;
  endtask

  task automatic host_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    host_valid = 1; host_write = wr; host_addr = a; host_wr_data = d; host_size = s;
  endtask

  initial begin
    core_idle();
    host_valid = 0; host_write = 0; host_addr = '0; host_wr_data = '0; host_size = '0;
    rst = 1;
    #2;
    // reset state, core path stays live during reset
    check("rst_ready", 32'(host_ready), 32'd1);
    check("rst_rd_valid", 32'(host_rd_valid), 32'd0);
    check("rst_starved", 32'(host_starved), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wr", 32'({mem_read, mem_write}), 32'd0);
    core_req = 1; core_read = 1; core_addr = 32'h20; core_size = 4'hF;
    #1;
    check("rst_core_gnt", 32'(core_gnt), 32'd1);
    check("rst_core_addr", mem_addr, 32'h20);
    check("rst_core_read", 32'(mem_read), 32'd1);
    core_idle();
    tick(); tick();
    rst = 0;
    tick();

    // host read, core idle
    host_req(0, 32'h10, 32'h0, 4'hF);
    #1;
    check("rd_idle_ready", 32'(host_ready), 32'd1);
    check("rd_idle_noacc", 32'({mem_read, mem_write}), 32'd0);
    tick();
    host_valid = 0;
    #1;
    check("rd_pend_ready", 32'(host_ready), 32'd0);
    check("rd_pend_strobe", 32'({mem_read, mem_write}), 32'b10);
    check("rd_pend_addr", mem_addr, 32'h10);
    check("rd_pend_size", 32'(mem_size), 32'hF);
    tick();
    check("rd_resp_valid", 32'(host_rd_valid), 32'd1);
    check("rd_resp_data", host_rd_data, 32'hA000_0004);
    check("rd_resp_noacc", 32'({mem_read, mem_write}), 32'd0);
    tick();
    check("rd_after_valid", 32'(host_rd_valid), 32'd0);
    check("rd_after_data", host_rd_data, 32'd0);
    check("rd_after_ready", 32'(host_ready), 32'd1);

    // host write blocked for 20 cycles by core loads
    host_req(1, 32'h08, 32'hDEAD_BEEF, 4'hF);
    tick();
    host_valid = 0;
    core_req = 1; core_read = 1; core_addr = 32'h00; core_size = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      #1;
      check($sformatf("blk_nowrite_%0d", k), 32'(mem_write), 32'd0);
      check($sformatf("blk_addr_%0d", k), mem_addr, 32'h00);
      check($sformatf("blk_starved_%0d", k), 32'(host_starved), 32'(k >= 17));
      tick();
    end
    core_idle();
    #1;
    check("blk_issue_strobe", 32'({mem_read, mem_write}), 32'b01);
    check("blk_issue_addr", mem_addr, 32'h08);
    check("blk_issue_data", mem_wr_data, 32'hDEAD_BEEF);
    check("blk_issue_starved", 32'(host_starved), 32'd1);
    tick();
    check("blk_after_starved", 32'(host_starved), 32'd0);
    check("blk_after_ready", 32'(host_ready), 32'd1);
    check("blk_sram", sram[2], 32'hDEAD_BEEF);

    // core store and host write in the same cycle
    core_req = 1; core_write = 1; core_addr = 32'h0C; core_wr_data = 32'h00AB_0000; core_size = 4'b0100;
    host_req(1, 32'h14, 32'h1122_3344, 4'hF);
    #1;
    check("same_gnt", 32'(core_gnt), 32'd1);
    check("same_core_addr", mem_addr, 32'h0C);
    check("same_core_size", 32'(mem_size), 32'b0100);
    check("same_core_write", 32'(mem_write), 32'd1);
    tick();
    core_idle(); host_valid = 0;
    #1;
    check("same_host_addr", mem_addr, 32'h14);
    check("same_host_data", mem_wr_data, 32'h1122_3344);
    check("same_host_write", 32'({mem_read, mem_write}), 32'b01);
    tick();
    check("same_sram_core", sram[3], 32'hA0AB_0003);
    check("same_sram_host", sram[5], 32'h1122_3344);

    // core load at N, host read issues at N+1
    host_req(0, 32'h18, 32'h0, 4'hF);
    tick();
    host_valid = 0;
    core_req = 1; core_read = 1; core_addr = 32'h1C; core_size = 4'hF;
    #1;
    check("ovl_core_addr", mem_addr, 32'h1C);
    tick();
    core_idle();
    #1;
    check("ovl_core_rd", core_rd_data, 32'hA000_0007);
    check("ovl_host_addr", mem_addr, 32'h18);
    check("ovl_host_read", 32'(mem_read), 32'd1);
    tick();
    check("ovl_host_valid", 32'(host_rd_valid), 32'd1);
    check("ovl_host_rd", host_rd_data, 32'hA000_0006);
    tick();

    // reset in PEND discards the request
    host_req(1, 32'h20, 32'hCAFE_F00D, 4'hF);
    tick();
    host_valid = 0;
    core_req = 1; core_read = 1; core_addr = 32'h04; core_size = 4'hF;
    #1;
    rst = 1;
    #1;
    check("rstp_ready", 32'(host_ready), 32'd1);
    check("rstp_core_addr", mem_addr, 32'h04);
    core_idle();
    #1;
    check("rstp_noacc", 32'({mem_read, mem_write}), 32'd0);
    tick();
    rst = 0;
    #1;
    check("rstp_ready2", 32'(host_ready), 32'd1);
    check("rstp_nowrite", 32'(mem_write), 32'd0);
    tick();
    check("rstp_rd_valid", 32'(host_rd_valid), 32'd0);
    check("rstp_sram", sram[8], 32'hA000_0008);

    // 300 blocked cycles: counter saturates, flag stays
    host_req(0, 32'h24, 32'h0, 4'hF);
    tick();
    host_valid = 0;
    core_req = 1; core_read = 1; core_addr = 32'h00; core_size = 4'hF;
    for (int k = 1; k <= 300; k++) begin
      #1;
      if (k >= 17) check($sformatf("sat_starved_%0d", k), 32'(host_starved), 32'd1);
      tick();
    end
    check("sat_cnt", 32'(dut.wait_cnt), 32'd255);
    core_idle();
    #1;
    check("sat_issue_addr", mem_addr, 32'h24);
    tick();
    check("sat_resp_data", host_rd_data, 32'hA000_0009);
    tick();

    // illegal core read+write forwarded unchanged
    core_req = 1; core_read = 1; core_write = 1; core_addr = 32'h30; core_size = 4'h3;
    #1;
    check("both_strobes", 32'({mem_read, mem_write}), 32'b11);
    check("both_size", 32'(mem_size), 32'h3);
    core_idle();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
